// File: rtl/wb_conmax_wrr_sched_pkg.sv
// Shared constants and types for the weighted round-robin slave-port scheduler.
// State encodings are fixed so external checkers can decode the FSM by value.
package wb_conmax_wrr_sched_pkg;

  localparam int NUM_MST = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Why the current owner loses the port; timeout outranks a dropped request.
  typedef enum logic [1:0] {
    REL_NONE  = 2'd0,
    REL_DROP  = 2'd1,
    REL_QUOTA = 2'd2,
    REL_TMO   = 2'd3
  } rel_t;

endpackage

// File: rtl/wb_conmax_rr_pick.sv
// Rotating-priority finder: returns the first set bit of i_elig scanning from
// i_ptr upwards with wrap 7->0.
module wb_conmax_rr_pick
  import wb_conmax_wrr_sched_pkg::*;
(
  input  logic [NUM_MST-1:0] i_elig,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_any
);

  logic [NUM_MST-1:0] w_rot;
  logic [SEL_W-1:0]   w_off;

  // w_rot[k] is the master k positions after the pointer.
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      w_rot[i] = i_elig[SEL_W'(i) + i_ptr];
    end
  end

  always_comb begin
    w_off = '0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
  end

  assign o_idx = i_ptr + w_off;
  assign o_any = |i_elig;

endmodule

// File: rtl/wb_conmax_wrr_sched.sv
// Weighted round-robin owner select for one shared slave port with per-grant
// termination quota, stall watchdog, and a one-cycle idle gap on every handover.
module wb_conmax_wrr_sched
  import wb_conmax_wrr_sched_pkg::*;
#(
  parameter int WW = 4,
  parameter int TW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_MST-1:0]   req_i,
  input  logic                 term_i,
  input  logic [NUM_MST*WW-1:0] wgt_i,
  input  logic [TW-1:0]        tmo_lim_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 sel_vld_o,
  output logic                 tmo_err_o,
  output logic [NUM_MST-1:0]   mask_o
);

  state_t             r_state, w_nxt_state;
  logic [SEL_W-1:0]   r_sel, w_nxt_sel;
  logic [SEL_W-1:0]   r_ptr, w_nxt_ptr;
  logic [WW-1:0]      r_credit, w_nxt_credit;
  logic [TW-1:0]      r_wdog, w_nxt_wdog;
  logic               r_tmo_err, w_nxt_tmo_err;
  logic [NUM_MST-1:0] r_mask, w_nxt_mask;

  logic [NUM_MST-1:0] w_elig;
  logic [NUM_MST-1:0] w_sel_bit;
  logic [SEL_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [WW-1:0]      w_pick_wgt, w_cur_wgt;
  logic [WW-1:0]      w_pick_quota, w_cur_quota;
  logic               w_others;
  logic               w_last_credit;
  logic               w_tmo_hit;
  rel_t               w_rel;

  assign w_elig    = req_i & ~r_mask;
  assign w_sel_bit = NUM_MST'(1) << r_sel;
  assign w_others  = |(w_elig & ~w_sel_bit);

  wb_conmax_rr_pick u_pick (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  // A zero weight still grants one termination.
  assign w_pick_wgt   = wgt_i[w_pick_idx*WW +: WW];
  assign w_cur_wgt    = wgt_i[r_sel*WW +: WW];
  assign w_pick_quota = (w_pick_wgt == '0) ? WW'(1) : w_pick_wgt;
  assign w_cur_quota  = (w_cur_wgt == '0) ? WW'(1) : w_cur_wgt;

  assign w_last_credit = (r_credit == WW'(1));
  // Compared one bit wider so a saturated counter can never alias onto the limit.
  assign w_tmo_hit = (tmo_lim_i != '0) && !term_i &&
                     (({1'b0, r_wdog} + (TW+1)'(1)) == {1'b0, tmo_lim_i});

  always_comb begin
    if (w_tmo_hit)                               w_rel = REL_TMO;
    else if (!req_i[r_sel])                      w_rel = REL_DROP;
    else if (term_i && w_last_credit && w_others) w_rel = REL_QUOTA;
    else                                         w_rel = REL_NONE;
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_sel     = r_sel;
    w_nxt_ptr     = r_ptr;
    w_nxt_credit  = r_credit;
    w_nxt_wdog    = r_wdog;
    w_nxt_tmo_err = 1'b0;
    w_nxt_mask    = r_mask & req_i;

    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_pick_any) begin
          w_nxt_state  = ST_GRANT;
          w_nxt_sel    = w_pick_idx;
          w_nxt_credit = w_pick_quota;
          w_nxt_wdog   = '0;
        end else begin
          w_nxt_state  = ST_IDLE;
        end
      end

      ST_GRANT: begin
        if (term_i) begin
          w_nxt_wdog   = '0;
          w_nxt_credit = w_last_credit ? w_cur_quota : r_credit - WW'(1);
        end else if (r_wdog != '1) begin
          w_nxt_wdog   = r_wdog + TW'(1);
        end

        if (w_rel != REL_NONE) begin
          w_nxt_state = ST_GAP;
          w_nxt_ptr   = r_sel + SEL_W'(1);
        end

        // The mask set wins over the same-cycle clear from a dropped request.
        if (w_rel == REL_TMO) begin
          w_nxt_tmo_err = 1'b1;
          w_nxt_mask    = w_nxt_mask | w_sel_bit;
        end
      end

      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_credit  <= '0;
      r_wdog    <= '0;
      r_tmo_err <= 1'b0;
      r_mask    <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_sel     <= w_nxt_sel;
      r_ptr     <= w_nxt_ptr;
      r_credit  <= w_nxt_credit;
      r_wdog    <= w_nxt_wdog;
      r_tmo_err <= w_nxt_tmo_err;
      r_mask    <= w_nxt_mask;
    end
  end

  assign sel_o     = r_sel;
  assign sel_vld_o = (r_state == ST_GRANT);
  assign tmo_err_o = r_tmo_err;
  assign mask_o    = r_mask;

endmodule

// File: tb/tb_wb_conmax_wrr_sched.sv
// Bench for wb_conmax_wrr_sched: directed scenarios with fixed expectations plus
// randomized traffic compared every cycle against a behavioural owner model.
module tb_wb_conmax_wrr_sched;

  localparam int WW = 4;
  localparam int TW = 8;
  localparam int OW = 13;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [7:0]      req_i;
  logic            term_i;
  logic [8*WW-1:0] wgt_i;
  logic [TW-1:0]   tmo_lim_i;
  logic [2:0]      sel_o;
  logic            sel_vld_o;
  logic            tmo_err_o;
  logic [7:0]      mask_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [OW-1:0] exp_q[$];

  // Reference model: who owns the port, and the bookkeeping behind that choice.
  int         m_sel, m_ptr, m_credit, m_wd;
  bit         m_vld, m_tmo;
  logic [7:0] m_mask;

  int wrr_exp[12]  = '{0, 0, 0, -1, 1, -1, 0, 0, 0, -1, 1, -1};
  int wrap_exp[6]  = '{7, -1, 0, 0, -1, 7};

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  wb_conmax_wrr_sched #(.WW(WW), .TW(TW)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .term_i    (term_i),
    .wgt_i     (wgt_i),
    .tmo_lim_i (tmo_lim_i),
    .sel_o     (sel_o),
    .sel_vld_o (sel_vld_o),
    .tmo_err_o (tmo_err_o),
    .mask_o    (mask_o)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // exp < 0 means no grant is expected.
  task automatic chk_grant(input string tag, input int exp);
    chk({tag, "_vld"}, 32'(sel_vld_o), 32'(exp >= 0));
    if (exp >= 0) chk({tag, "_sel"}, 32'(sel_o), 32'(exp));
  endtask

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [7:0] elig, input int ptr);
    for (int k = 0; k < 8; k++) begin
      if (elig[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return 0;
  endfunction

  function automatic int quota(input int n);
    int w;
    w = int'(wgt_i[n*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_step();
    logic [7:0] elig, nmask;
    bit others, tmo_hit, rel;
    if (rst_i) begin
      m_sel = 0; m_ptr = 0; m_credit = 0; m_wd = 0;
      m_vld = 0; m_tmo = 0; m_mask = '0;
    end else begin
      elig  = req_i & ~m_mask;
      nmask = m_mask & req_i;
      m_tmo = 0;
      if (!m_vld) begin
        if (elig != 0) begin
          m_sel    = rr_pick(elig, m_ptr);
          m_vld    = 1;
          m_credit = quota(m_sel);
          m_wd     = 0;
        end
      end else begin
        others  = (elig & ~(8'(1) << m_sel)) != 0;
        tmo_hit = (tmo_lim_i != 0) && !term_i && (m_wd + 1 == int'(tmo_lim_i));
        rel     = !req_i[m_sel] || (term_i && m_credit == 1 && others) || tmo_hit;
        if (term_i) begin
          m_wd     = 0;
          m_credit = (m_credit == 1) ? quota(m_sel) : m_credit - 1;
        end else if (m_wd < 255) begin
          m_wd++;
        end
        if (rel) begin
          m_vld = 0;
          m_ptr = (m_sel + 1) % 8;
          if (tmo_hit) begin
            m_tmo = 1;
            nmask[m_sel] = 1'b1;
          end
        end
      end
      m_mask = nmask;
    end
    exp_q.push_back({3'(m_sel), m_vld, m_tmo, m_mask});
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input string tag);
    logic [OW-1:0] e;
    @(posedge clk_i);
    model_step();
    #1;
    e = exp_q.pop_front();
    chk(tag, 32'({sel_o, sel_vld_o, tmo_err_o, mask_o}), 32'(e));
  endtask

  task automatic set_wgt(input int n, input int w);
    wgt_i[n*WW +: WW] = WW'(w);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int term_pct;
    logic [7:0] tog;

    rst_i = 1'b1; req_i = '0; term_i = 1'b0; wgt_i = '0; tmo_lim_i = '0;
    repeat (3) cycle("rst");
    chk("rst_vals", 32'({sel_o, sel_vld_o, tmo_err_o, mask_o}), 32'd0);
    rst_i = 1'b0;

    // Single master: one-cycle grant latency, release on request drop.
    repeat (2) cycle("idle");
    req_i = 8'h04;
    cycle("single");        chk_grant("single", 2);
    repeat (10) cycle("single_hold"); chk_grant("single_hold", 2);
    req_i = 8'h00;
    cycle("single_drop");   chk_grant("single_drop", -1);
    repeat (3) cycle("single_idle"); chk_grant("single_idle", -1);

    // Weighted sharing between masters 0 (weight 3) and 1 (weight 1).
    set_wgt(0, 3); set_wgt(1, 1);
    req_i = 8'h03; term_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle("wrr");
      chk_grant($sformatf("wrr%0d", i), wrr_exp[i]);
    end
    req_i = 8'h00; term_i = 1'b0;
    repeat (3) cycle("wrr_idle");

    // Park the pointer at 7 via master 6, then zero weight on master 7.
    req_i = 8'h40; cycle("park"); chk_grant("park", 6);
    req_i = 8'h00; repeat (2) cycle("park_rel");
    set_wgt(7, 0); set_wgt(0, 2);
    req_i = 8'h81; term_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle("wrap");
      chk_grant($sformatf("wrap%0d", i), wrap_exp[i]);
    end
    req_i = 8'h00; term_i = 1'b0;
    repeat (3) cycle("wrap_idle");

    // Watchdog preemption of master 3 after 5 stalled cycles.
    tmo_lim_i = 8'd5; set_wgt(3, 2);
    req_i = 8'h08;
    cycle("wd");            chk_grant("wd_grant", 3);
    repeat (4) cycle("wd");
    chk_grant("wd_hold", 3); chk("wd_no_err", 32'(tmo_err_o), 32'd0);
    cycle("wd");
    chk_grant("wd_rel", -1);
    chk("wd_err", 32'(tmo_err_o), 32'd1);
    chk("wd_mask", 32'(mask_o), 32'h08);
    cycle("wd");            chk("wd_err_pulse", 32'(tmo_err_o), 32'd0);
    repeat (5) cycle("wd_masked");
    chk_grant("wd_masked", -1); chk("wd_mask_hold", 32'(mask_o), 32'h08);
    req_i = 8'h00;
    cycle("wd_unmask");     chk("wd_mask_clr", 32'(mask_o), 32'h00);
    req_i = 8'h08;
    cycle("wd_regrant");    chk_grant("wd_regrant", 3);

    // Termination exactly in the limit cycle clears the watchdog.
    repeat (4) cycle("wdb");
    term_i = 1'b1;
    cycle("wdb_lim");
    chk_grant("wdb_lim", 3); chk("wdb_no_err", 32'(tmo_err_o), 32'd0);
    term_i = 1'b0;
    repeat (4) cycle("wdb_after");
    chk_grant("wdb_after", 3); chk("wdb_after_err", 32'(tmo_err_o), 32'd0);
    cycle("wdb_fire");      chk("wdb_fire", 32'(tmo_err_o), 32'd1);
    req_i = 8'h00; cycle("wdb_unmask");
    req_i = 8'h08; cycle("wdb_regrant"); chk_grant("wdb_regrant", 3);

    // Watchdog disabled for 300 stall cycles, then a limit a wrapped count would hit.
    tmo_lim_i = 8'd0;
    repeat (300) cycle("sat");
    chk_grant("sat_hold", 3); chk("sat_no_err", 32'(tmo_err_o), 32'd0);
    tmo_lim_i = 8'd50;
    repeat (20) cycle("sat_lim");
    chk_grant("sat_lim_hold", 3); chk("sat_lim_no_err", 32'(tmo_err_o), 32'd0);
    tmo_lim_i = 8'd0;

    // Reset in the middle of a grant to master 5.
    req_i = 8'h20;
    repeat (2) cycle("to5");  chk_grant("to5", 5);
    rst_i = 1'b1;
    cycle("rst_mid");
    chk("rst_mid_vals", 32'({sel_o, sel_vld_o, tmo_err_o, mask_o}), 32'd0);
    rst_i = 1'b0;
    cycle("rst_regrant");   chk_grant("rst_regrant", 5);
    rst_i = 1'b1; cycle("rst2");
    rst_i = 1'b0; req_i = 8'h22;
    cycle("rst_ptr");       chk_grant("rst_ptr", 1);

    // Randomized traffic against the model.
    term_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        wgt_i     = $urandom;
        tmo_lim_i = TW'($urandom_range(0, 12));
        term_pct  = $urandom_range(0, 90);
      end
      for (int b = 0; b < 8; b++) tog[b] = ($urandom_range(0, 9) == 0);
      req_i  = req_i ^ tog;
      term_i = ($urandom_range(0, 99) < term_pct);
      rst_i  = ($urandom_range(0, 399) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
